// File: rtl/hvac_pkg.sv
// Shared types and parameter checks for the HVAC actuator sequencer.
package hvac_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEAT    = 3'd1,
        COOL    = 3'd2,
        RUNON   = 3'd3,
        LOCKOUT = 3'd4
    } hvac_state_t;

    // Every dwell value must be at least 1 and must fit in the dwell counter.
    function automatic bit hvac_params_ok(input int min_on, input int min_off,
                                          input int fan_runon, input int cnt_w);
        bit ok;
        ok = (cnt_w >= 1) && (cnt_w <= 30);
        ok = ok && (min_on >= 1) && (min_off >= 1) && (fan_runon >= 1);
        if (ok) begin
            ok = (min_on < (1 << cnt_w)) && (min_off < (1 << cnt_w))
                 && (fan_runon < (1 << cnt_w));
        end
        return ok;
    endfunction

endpackage

// File: rtl/hvac_dwell_timer.sv
// Dwell counter: synchronous clear, otherwise counts up and sticks at all-ones.
module hvac_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hvac_actuator_seq.sv
// Turns thermostat heat/cool/fan requests into actuator enables while enforcing
// minimum on-time, fan run-on and a minimum off-time between heat/cool runs.
module hvac_actuator_seq
    import hvac_pkg::*;
#(
    parameter int MIN_ON    = 4,
    parameter int MIN_OFF   = 6,
    parameter int FAN_RUNON = 3,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic heater_req,
    input  logic aircon_req,
    input  logic fan_req,
    output logic heater_en,
    output logic aircon_en,
    output logic fan_en,
    output logic lockout,
    output logic conflict
);

    if (!hvac_params_ok(MIN_ON, MIN_OFF, FAN_RUNON, CNT_W)) begin : g_param_check
        $error("hvac_actuator_seq: illegal MIN_ON/MIN_OFF/FAN_RUNON/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] RUNON_LAST = CNT_W'(FAN_RUNON - 1);
    // When the run-on alone already covers the off time there is no lockout tail.
    localparam bit RUNON_TO_LOCK = (MIN_OFF > FAN_RUNON);

    hvac_state_t      state_q;
    hvac_state_t      state_d;
    logic             fan_req_q;
    logic             conflict_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             heat_r;
    logic             cool_r;

    // Simultaneous heat and cool requests are treated as no request at all.
    assign heat_r = heater_req & ~aircon_req;
    assign cool_r = aircon_req & ~heater_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (heat_r) begin
                    state_d = HEAT;
                end else if (cool_r) begin
                    state_d = COOL;
                end
            end
            HEAT: begin
                if ((cnt >= ON_LAST) && !heat_r) state_d = RUNON;
            end
            COOL: begin
                if ((cnt >= ON_LAST) && !cool_r) state_d = RUNON;
            end
            RUNON: begin
                if (cnt == RUNON_LAST) state_d = RUNON_TO_LOCK ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (cnt >= OFF_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // LOCKOUT keeps counting from the run-on value so the total off time is MIN_OFF.
    always_comb begin
        cnt_clr = 1'b0;
        if (state_d == IDLE) begin
            cnt_clr = 1'b1;
        end else if ((state_d != state_q) && (state_d != LOCKOUT)) begin
            cnt_clr = 1'b1;
        end
    end

    hvac_dwell_timer #(
        .CNT_W(CNT_W)
    ) u_dwell (
        .clk   (clk),
        .resetn(resetn),
        .clr_i (cnt_clr),
        .cnt_o (cnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            fan_req_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fan_req_q  <= fan_req;
            conflict_q <= heater_req & aircon_req;
        end
    end

    assign heater_en = (state_q == HEAT);
    assign aircon_en = (state_q == COOL);
    assign fan_en    = (state_q == HEAT) || (state_q == COOL) || (state_q == RUNON) || fan_req_q;
    assign lockout   = (state_q == RUNON) || (state_q == LOCKOUT);
    assign conflict  = conflict_q;

endmodule
